// File: rtl/data_mem_pkg.sv
// Shared state encoding, word type and address helpers for the byte-banked data memory.
package data_mem_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT} state_e;

  typedef logic [0:BYTES_PER_WORD-1][7:0] word_t;

  function automatic logic [1:0] bank_of(input logic [31:0] a);
    return 2'(a);
  endfunction

  function automatic logic [31:0] row_of(input logic [31:0] a, input int unsigned depth);
    return (a & (depth - 32'd1)) >> 2;
  endfunction

endpackage

// File: rtl/mem_byte_bank.sv
// One byte lane of the data memory: synchronous write, registered read.
module mem_byte_bank #(
  parameter int unsigned ROWS  = 256,
  parameter int unsigned ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ROW_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [ROW_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed data memory responding to the ALU memory port; four byte banks with
// lane rotation for misaligned access, post-reset clear, and programmable read latency.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     mem_addr,
  input  logic            mem_write_en,
  input  logic [0:3][7:0] mem_data_in,
  output logic [0:3][7:0] mem_data_out,
  output logic            mem_busy,
  output logic            mem_oob
);

  localparam int unsigned ROWS     = DEPTH / BYTES_PER_WORD;
  localparam int unsigned ROW_W    = $clog2(ROWS);
  localparam int unsigned CNT_W    = $clog2(LATENCY) + 1;
  localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] clr_row_q, clr_row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_addr_q, pend_addr_d;
  logic [31:0]      last_addr_q, last_addr_d;
  word_t            dout_q, dout_d, rd_word;
  logic             sel_ram_q, sel_ram_d;
  logic [1:0]       rot_q, rot_d;
  logic             busy_d, oob_d, addr_oob;
  logic             clearing, commit, bank_we;

  logic [ROW_W-1:0] base_row;
  logic [ROW_W-1:0] acc_row    [BYTES_PER_WORD];
  logic [1:0]       wr_lane    [BYTES_PER_WORD];
  logic [ROW_W-1:0] bank_waddr [BYTES_PER_WORD];
  logic [7:0]       bank_wdata [BYTES_PER_WORD];
  logic [7:0]       bank_rdata [BYTES_PER_WORD];

  assign addr_oob = (mem_addr >= 32'(DEPTH));
  assign bank_we  = clearing | commit;
  assign busy_d   = (state_d != IDLE);

  // Output is a flop-driven select: rotated bank read registers after a read, else the held word.
  assign mem_data_out = sel_ram_q ? rd_word : dout_q;

  // Bank b holds lane (b - a[1:0]); banks below the start lane carry into the next row.
  always_comb begin
    base_row = ROW_W'(row_of(mem_addr, DEPTH));
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      wr_lane[b]    = 2'(b) - bank_of(mem_addr);
      acc_row[b]    = base_row + ROW_W'(2'(b) < bank_of(mem_addr));
      bank_wdata[b] = clearing ? 8'h00 : mem_data_in[wr_lane[b]];
      bank_waddr[b] = clearing ? clr_row_q : acc_row[b];
      rd_word[b]    = bank_rdata[2'(b) + rot_q];
    end
  end

  for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_bank
    mem_byte_bank #(
      .ROWS (ROWS),
      .ROW_W(ROW_W)
    ) u_bank (
      .clk  (clk),
      .we   (bank_we),
      .waddr(bank_waddr[g]),
      .wdata(bank_wdata[g]),
      .raddr(acc_row[g]),
      .rdata(bank_rdata[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    clr_row_d   = clr_row_q;
    cnt_d       = cnt_q;
    pend_addr_d = pend_addr_q;
    last_addr_d = last_addr_q;
    dout_d      = dout_q;
    sel_ram_d   = sel_ram_q;
    rot_d       = rot_q;
    oob_d       = mem_oob;
    clearing    = 1'b0;
    commit      = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clearing  = 1'b1;
        clr_row_d = clr_row_q + 1'b1;
        if (clr_row_q == ROW_W'(ROWS - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (mem_write_en) begin
          commit = 1'b1;
        end else if (mem_addr != last_addr_q) begin
          if (LATENCY == 1) begin
            sel_ram_d   = 1'b1;
            rot_d       = bank_of(mem_addr);
            last_addr_d = mem_addr;
            oob_d       = addr_oob;
          end else begin
            state_d     = WAIT;
            pend_addr_d = mem_addr;
            cnt_d       = CNT_W'(CNT_INIT);
            dout_d      = mem_data_out;
            sel_ram_d   = 1'b0;
          end
        end
      end
      WAIT: begin
        if (mem_write_en) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else if (mem_addr != pend_addr_q) begin
          pend_addr_d = mem_addr;
          cnt_d       = CNT_W'(CNT_INIT);
        end else if (cnt_q == '0) begin
          // Address held through the wait, so the banks already present pend_addr data.
          sel_ram_d   = 1'b1;
          rot_d       = bank_of(pend_addr_q);
          last_addr_d = pend_addr_q;
          oob_d       = (pend_addr_q >= 32'(DEPTH));
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
    if (commit) begin
      dout_d      = mem_data_in;
      sel_ram_d   = 1'b0;
      last_addr_d = mem_addr;
      oob_d       = addr_oob;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= CLEAR;
      clr_row_q   <= '0;
      cnt_q       <= '0;
      pend_addr_q <= '0;
      last_addr_q <= '0;
      dout_q      <= '0;
      sel_ram_q   <= 1'b0;
      rot_q       <= '0;
      mem_busy    <= 1'b1;
      mem_oob     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_row_q   <= clr_row_d;
      cnt_q       <= cnt_d;
      pend_addr_q <= pend_addr_d;
      last_addr_q <= last_addr_d;
      dout_q      <= dout_d;
      sel_ram_q   <= sel_ram_d;
      rot_q       <= rot_d;
      mem_busy    <= busy_d;
      mem_oob     <= oob_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three DEPTH=64 instances at LATENCY 1, 3 and 4.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef logic [0:3][7:0] word_t;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    word_t       din;
    word_t       data;
    logic        oob;
  } vec_t;

  typedef struct {
    string name;
    word_t data;
    logic  oob;
  } exp_t;

  logic        clk;
  logic        rst_b;
  logic [31:0] addr1, addr3, addr4;
  logic        we1, we3, we4;
  word_t       din1, din3, din4, dout1, dout3, dout4;
  logic        busy1, busy3, busy4, oob1, oob3, oob4;

  int checks = 0;
  int errors = 0;
  vec_t vecs [$];
  exp_t sb_q [$];

  logic [7:0]  model [DEPTH];
  logic [31:0] m_last;
  word_t       m_out;
  logic        m_oob;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_b(rst_b), .mem_addr(addr1), .mem_write_en(we1),
    .mem_data_in(din1), .mem_data_out(dout1), .mem_busy(busy1), .mem_oob(oob1));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst_b(rst_b), .mem_addr(addr3), .mem_write_en(we3),
    .mem_data_in(din3), .mem_data_out(dout3), .mem_busy(busy3), .mem_oob(oob3));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst_b(rst_b), .mem_addr(addr4), .mem_write_en(we4),
    .mem_data_in(din4), .mem_data_out(dout4), .mem_busy(busy4), .mem_oob(oob4));

  function automatic logic busy_of(input int k);
    case (k)
      1:       return busy1;
      3:       return busy3;
      default: return busy4;
    endcase
  endfunction

  function automatic word_t dout_of(input int k);
    case (k)
      1:       return dout1;
      3:       return dout3;
      default: return dout4;
    endcase
  endfunction

  function automatic logic oob_of(input int k);
    case (k)
      1:       return oob1;
      3:       return oob3;
      default: return oob4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input word_t data, input logic oob);
    exp_t e;
    e.name = name;
    e.data = data;
    e.oob  = oob;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int k);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got no expected entry for lat%0d", k);
      return;
    end
    e = sb_q.pop_front();
    check({e.name, "_data"}, dout_of(k), e.data);
    check({e.name, "_oob"}, 32'(oob_of(k)), 32'(e.oob));
  endtask

  // Counts negedges with busy high, starting at the current one; bounded.
  task automatic wait_ready(input int k, input string name, output int n);
    n = 0;
    while (busy_of(k) && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (busy_of(k)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still high after %0d cycles", name, n);
    end
  endtask

  task automatic add_vec(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] din, input logic [31:0] data, input logic oob);
    vec_t v;
    v.name = name;
    v.we   = we;
    v.addr = addr;
    v.din  = din;
    v.data = data;
    v.oob  = oob;
    vecs.push_back(v);
  endtask

  // Reference model of the LATENCY=1 instance.
  task automatic model_step(input logic we, input logic [31:0] addr, input word_t din);
    int unsigned idx;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        idx = (addr + 32'(i)) % DEPTH;
        model[AW'(idx)] = din[i];
      end
      m_out  = din;
      m_last = addr;
      m_oob  = (addr >= DEPTH);
    end else if (addr != m_last) begin
      for (int i = 0; i < 4; i++) begin
        idx = (addr + 32'(i)) % DEPTH;
        m_out[i] = model[AW'(idx)];
      end
      m_last = addr;
      m_oob  = (addr >= DEPTH);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_b = 1'b0;
    we1 = 1'b0; we3 = 1'b0; we4 = 1'b0;
    addr1 = '0; addr3 = '0; addr4 = '0;
    din1 = '0; din3 = '0; din4 = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    m_last = '0;
    m_out  = '0;
    m_oob  = 1'b0;

    // Reset state and clear length
    repeat (2) @(negedge clk);
    check("rst_busy1", 32'(busy1), 32'd1);
    check("rst_busy4", 32'(busy4), 32'd1);
    check("rst_dout1", dout1, 32'h0);
    check("rst_oob3", 32'(oob3), 32'd0);
    rst_b = 1'b1;
    wait_ready(1, "clear", n);
    check("clear_cycles", 32'(n), 32'd16);
    check("clear_busy3", 32'(busy3), 32'd0);
    check("clear_busy4", 32'(busy4), 32'd0);

    // LATENCY=1 table: aligned, misaligned, wrap, hold, forwarding, out-of-range alias
    add_vec("rd20",      1'b0, 32'h20, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    add_vec("wr10",      1'b1, 32'h10, 32'hEFBEADDE, 32'hEFBEADDE, 1'b0);
    add_vec("rd00",      1'b0, 32'h00, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    add_vec("rd10",      1'b0, 32'h10, 32'hFFFFFFFF, 32'hEFBEADDE, 1'b0);
    add_vec("wr3e",      1'b1, 32'h3E, 32'h11223344, 32'h11223344, 1'b0);
    add_vec("rd00_wrap", 1'b0, 32'h00, 32'hFFFFFFFF, 32'h33440000, 1'b0);
    add_vec("rd3e",      1'b0, 32'h3E, 32'hFFFFFFFF, 32'h11223344, 1'b0);
    add_vec("rd3c",      1'b0, 32'h3C, 32'hFFFFFFFF, 32'h00001122, 1'b0);
    add_vec("rd3c_hold", 1'b0, 32'h3C, 32'hFFFFFFFF, 32'h00001122, 1'b0);
    add_vec("wr48_oob",  1'b1, 32'h48, 32'hAABBCCDD, 32'hAABBCCDD, 1'b1);
    add_vec("rd08",      1'b0, 32'h08, 32'hFFFFFFFF, 32'hAABBCCDD, 1'b0);
    add_vec("rd48_alias",1'b0, 32'h48, 32'hFFFFFFFF, 32'hAABBCCDD, 1'b1);
    add_vec("wr05",      1'b1, 32'h05, 32'h01020304, 32'h01020304, 1'b0);
    add_vec("rd04",      1'b0, 32'h04, 32'hFFFFFFFF, 32'h00010203, 1'b0);
    add_vec("rd08_mix",  1'b0, 32'h08, 32'hFFFFFFFF, 32'h04BBCCDD, 1'b0);
    add_vec("wr08_same", 1'b1, 32'h08, 32'h55667788, 32'h55667788, 1'b0);
    add_vec("rd08_hold", 1'b0, 32'h08, 32'hFFFFFFFF, 32'h55667788, 1'b0);
    add_vec("rd09",      1'b0, 32'h09, 32'hFFFFFFFF, 32'h66778800, 1'b0);
    add_vec("rd3f",      1'b0, 32'h3F, 32'hFFFFFFFF, 32'h22334400, 1'b0);
    foreach (vecs[i]) begin
      we1   = vecs[i].we;
      addr1 = vecs[i].addr;
      din1  = vecs[i].din;
      model_step(vecs[i].we, vecs[i].addr, vecs[i].din);
      sb_push(vecs[i].name, vecs[i].data, vecs[i].oob);
      @(negedge clk);
      sb_pop(1);
    end

    // LATENCY=1 random traffic against the model
    for (int i = 0; i < 40; i++) begin
      we1   = ($urandom_range(0, 2) == 0);
      addr1 = 32'($urandom_range(0, 127));
      din1  = $urandom;
      model_step(we1, addr1, din1);
      sb_push("rnd", m_out, m_oob);
      @(negedge clk);
      sb_pop(1);
    end
    we1 = 1'b0;

    // LATENCY=3: wait states and restart on address change
    we3 = 1'b1; addr3 = 32'h10; din3 = 32'hCAFEF00D;
    @(negedge clk);
    check("l3_wr_fwd", dout3, 32'hCAFEF00D);
    check("l3_wr_busy", 32'(busy3), 32'd0);
    addr3 = 32'h14; din3 = 32'h12345678;
    @(negedge clk);
    check("l3_wr2_fwd", dout3, 32'h12345678);
    we3 = 1'b0; addr3 = 32'h10;
    sb_push("l3_rd10", 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    check("l3_hold_during_wait", dout3, 32'h12345678);
    wait_ready(3, "l3_rd10", n);
    check("l3_busy_len", 32'(n), 32'd2);
    sb_pop(3);
    addr3 = 32'h18;
    sb_push("l3_restart", 32'h12345678, 1'b0);
    @(negedge clk);
    check("l3_restart_busy", 32'(busy3), 32'd1);
    addr3 = 32'h14;
    @(negedge clk);
    wait_ready(3, "l3_restart", n);
    check("l3_restart_len", 32'(n), 32'd2);
    sb_pop(3);
    addr3 = 32'h50;
    sb_push("l3_rd50_oob", 32'hCAFEF00D, 1'b1);
    @(negedge clk);
    wait_ready(3, "l3_rd50", n);
    check("l3_oob_len", 32'(n), 32'd2);
    sb_pop(3);

    // LATENCY=4: write preempts a pending read
    we4 = 1'b1; addr4 = 32'h10; din4 = 32'h0BADBEEF;
    @(negedge clk);
    addr4 = 32'h30; din4 = 32'h5A5A5A5A;
    @(negedge clk);
    check("l4_wr_fwd", dout4, 32'h5A5A5A5A);
    we4 = 1'b0; addr4 = 32'h10;
    @(negedge clk);
    check("l4_busy_c1", 32'(busy4), 32'd1);
    @(negedge clk);
    check("l4_busy_c2", 32'(busy4), 32'd1);
    we4 = 1'b1; addr4 = 32'h20; din4 = 32'h01020304;
    sb_push("l4_preempt", 32'h01020304, 1'b0);
    @(negedge clk);
    check("l4_preempt_busy", 32'(busy4), 32'd0);
    sb_pop(4);
    we4 = 1'b0;
    repeat (4) @(negedge clk);
    check("l4_read_dropped", dout4, 32'h01020304);
    check("l4_idle_after_drop", 32'(busy4), 32'd0);
    addr4 = 32'h21;
    sb_push("l4_rd21", 32'h02030400, 1'b0);
    @(negedge clk);
    wait_ready(4, "l4_rd21", n);
    check("l4_busy_len", 32'(n), 32'd3);
    sb_pop(4);

    // Reset in the middle of a wait restarts the clear
    addr4 = 32'h10;
    @(negedge clk);
    check("l4_rst_pre_busy", 32'(busy4), 32'd1);
    rst_b = 1'b0;
    addr4 = 32'h00;
    @(negedge clk);
    check("l4_rst_busy", 32'(busy4), 32'd1);
    check("l4_rst_dout", dout4, 32'h0);
    check("l1_rst_dout", dout1, 32'h0);
    rst_b = 1'b1;
    we1 = 1'b1; addr1 = 32'h3C; din1 = 32'hFFFFFFFF;
    @(negedge clk);
    check("clear_ignores_we", dout1, 32'h0);
    we1 = 1'b0; addr1 = 32'h10;
    wait_ready(1, "reclear", n);
    check("reclear_cycles", 32'(n), 32'd15);
    @(negedge clk);
    check("l1_after_clear", dout1, 32'h0);
    addr4 = 32'h10;
    sb_push("l4_after_clear", 32'h00000000, 1'b0);
    @(negedge clk);
    wait_ready(4, "l4_after_clear", n);
    check("l4_after_clear_len", 32'(n), 32'd3);
    sb_pop(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Byte-addressed data memory. It is the responder for the ALU memory port: mem_addr, mem_write_en and the four-byte mem_data_in / mem_data_out arrays, little-endian, with byte 0 at mem_addr.
- Stores take a full pre-merged 4-byte word. The ALU does sub-word read-modify-write itself.
- Loads return 4 bytes starting at mem_addr after a configurable latency.
- mem_busy reports wait states and the post-reset clear sequence.

Parameters:
DEPTH, 1024, memory size in bytes; power of two, >= 8.
LATENCY, 1, cycles from a new read address to valid mem_data_out; >= 1.

Ports:
clk  in  1  rising-edge clock
rst_b  in  1  synchronous active-low reset
mem_addr  in  32  byte address of access (low log2(DEPTH) bits used)
mem_write_en  in  1  commit mem_data_in at mem_addr this cycle
mem_data_in  in  8 x [0:3]  store bytes; [i] goes to mem_addr+i
mem_data_out  out  8 x [0:3]  load bytes; [i] from mem_addr+i
mem_busy  out  1  high while clearing or while a read is pending
mem_oob  out  1  registered; set if mem_addr >= DEPTH on the last accepted access

Behaviour:
- Interface: one clock, clk. Reset rst_b is synchronous and active-low.
- Storage: four byte banks; bank = a[1:0], row = a[log2(DEPTH)-1:2], with ROWS = DEPTH/4.
  - Byte i of an access uses address a+i, taken modulo DEPTH, so accesses may be misaligned.
  - An access at DEPTH-2 wraps to bytes 0 and 1.
- Reset (rst_b=0 sampled at an edge):
  - state <= CLEAR, clr_row <= 0, mem_busy <= 1.
  - mem_data_out <= all 0, mem_oob <= 0, last_addr <= 0.
- CLEAR:
  - Each cycle zeroes row clr_row in all four banks, then clr_row increments.
  - After row ROWS-1: state <= IDLE, mem_busy <= 0.
  - Takes exactly ROWS cycles.
  - mem_write_en and mem_addr are ignored.
  - Reset asserted during CLEAR restarts the clear at row 0.
- IDLE:
  - Write (mem_write_en=1): all four bytes are written at the edge. mem_data_out <= mem_data_in (write forwarding), last_addr <= mem_addr. Stay in IDLE; mem_busy stays 0.
  - Read, LATENCY=1 (mem_addr != last_addr, no write): mem_data_out <= read(mem_addr) at the next edge, last_addr <= mem_addr. mem_busy is never asserted.
  - Read, LATENCY>1: state <= WAIT, pend_addr <= mem_addr, cnt <= LATENCY-2, mem_busy <= 1. mem_data_out holds its old value.
  - mem_addr == last_addr with no write: no action; mem_data_out holds.
- WAIT:
  - Write has priority: commit and forward as in IDLE, drop the pending read, state <= IDLE, mem_busy <= 0.
  - mem_addr != pend_addr: pend_addr <= mem_addr, cnt <= LATENCY-2, restarting the wait.
  - cnt == 0: mem_data_out <= read(pend_addr), last_addr <= pend_addr, mem_busy <= 0, state <= IDLE.
  - Otherwise cnt decrements.
- mem_oob updates on every committed write and every completed read. It is never an error stop: the access still wraps.
- mem_data_out is always registered and never combinational from mem_addr.
- Counter width is clog2(LATENCY)+1. The address compare uses the full 32 bits, so an out-of-range alias of last_addr still counts as a new address.

Decomposition:
- Package data_mem_pkg:
  - state enum {CLEAR, IDLE, WAIT}
  - BYTES_PER_WORD = 4
  - functions bank_of(a) and row_of(a, DEPTH)
- Sub-module mem_byte_bank: one 8-bit synchronous RAM, ROWS deep. Ports: clk, we, waddr, wdata, raddr, rdata (registered read).
  - Instantiated four times.
  - The top level rotates byte lanes by mem_addr[1:0] and handles the row+1 carry for misaligned accesses.

Test Plan:
1. Reset clear: rst_b low for 2 cycles, then high, DEPTH=64. Expect mem_busy high for exactly 16 cycles, then 0. A read at 0x20 returns {00,00,00,00}.
2. Aligned store/load, LATENCY=1: write 0x10 with [0..3]={EF,BE,AD,DE}. The next edge shows the same bytes on mem_data_out. Read 0x00, then 0x10: returns {EF,BE,AD,DE} one cycle after the address change.
3. Misaligned wrap, DEPTH=64: write 0x3E with {11,22,33,44}. Read 0x00 returns {33,44,00,00}. Read 0x3E returns {11,22,33,44}.
4. Wait states, LATENCY=3:
   - Read 0x10: mem_busy high 2 cycles; data valid on the 3rd edge.
   - Changing the address to 0x14 in the 1st busy cycle restarts the wait: busy 2 more cycles.
5. Write preempts WAIT, LATENCY=4: start read 0x10, then write 0x20 {01,02,03,04} in the 2nd busy cycle. mem_busy drops next edge, mem_data_out = {01,02,03,04}, and the pending read is dropped.
6. Out-of-range, DEPTH=64: write 0x48 {AA,BB,CC,DD} sets mem_oob=1. Read 0x08 returns {AA,BB,CC,DD} with mem_oob=0. Reset mid-WAIT forces CLEAR with mem_data_out=0.
